// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte producers.
// A grant lasts one packet (until a byte flagged last) or until the owner stalls TIMEOUT cycles.
module uart_tx_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int TIMEOUT = 27000
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [NUM_REQ-1:0]   i_req_valid,
   input  logic [NUM_REQ*8-1:0] i_req_data,
   input  logic [NUM_REQ-1:0]   i_req_last,
   output logic [NUM_REQ-1:0]   o_req_ready,
   output logic [NUM_REQ-1:0]   o_grant,
   output logic                 o_tx_start,
   output logic [7:0]           o_tx_data,
   input  logic                 i_tx_busy,
   output logic                 o_busy,
   output logic                 o_timeout,
   output logic [2:0]           o_dbg_state
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);
   localparam logic [PW-1:0] PTR_RST = PW'(NUM_REQ - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_ACCEPT    = 3'd1,
      S_START     = 3'd2,
      S_WAIT_BUSY = 3'd3,
      S_WAIT_DONE = 3'd4,
      S_HOLD      = 3'd5
   } state_t;

   // Handshake: a requester holds valid high with data/last stable; the byte is taken at
   // the clock edge that ends the single cycle in which its o_req_ready bit is high.

   state_t               state_q, state_d;
   logic [PW-1:0]        ptr_q, ptr_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 last_q, last_d;
   logic [NUM_REQ-1:0]   grant_q, grant_d;
   logic [NUM_REQ-1:0]   ready_q, ready_d;
   logic                 tx_start_q, tx_start_d;
   logic [7:0]           tx_data_q, tx_data_d;
   logic                 busy_q, busy_d;
   logic                 timeout_q, timeout_d;

   logic [7:0]           req_byte [NUM_REQ];
   logic                 found;
   logic [PW-1:0]        win;
   logic [PW-1:0]        cand;

   for (genvar k = 0; k < NUM_REQ; k++) begin : g_byte
      assign req_byte[k] = i_req_data[8*k +: 8];
   end

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      cnt_d      = cnt_q;
      last_d     = last_q;
      grant_d    = grant_q;
      tx_data_d  = tx_data_q;
      timeout_d  = 1'b0;
      found      = 1'b0;
      win        = ptr_q;
      cand       = ptr_q;

      case (state_q)
         S_IDLE: begin
            // Search starts just after the previous owner so every requester gets a turn.
            for (int i = 1; i <= NUM_REQ; i++) begin
               cand = PW'((int'(ptr_q) + i) % NUM_REQ);
               if (!found && i_req_valid[cand]) begin
                  found = 1'b1;
                  win   = cand;
               end
            end
            if (found) begin
               ptr_d   = win;
               grant_d = NUM_REQ'(1) << win;
               state_d = S_ACCEPT;
            end
         end
         S_ACCEPT: begin
            tx_data_d = req_byte[ptr_q];
            last_d    = i_req_last[ptr_q];
            state_d   = S_START;
         end
         S_START: begin
            state_d = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            if (i_tx_busy) state_d = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            if (!i_tx_busy) begin
               if (last_q) begin
                  grant_d = '0;
                  state_d = S_IDLE;
               end else begin
                  cnt_d   = '0;
                  state_d = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            // The owner's next byte beats an expiring timeout on the same cycle.
            if (i_req_valid[ptr_q]) begin
               state_d = S_ACCEPT;
            end else if (cnt_q >= CNT_MAX) begin
               timeout_d = 1'b1;
               grant_d   = '0;
               state_d   = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            grant_d = '0;
            state_d = S_IDLE;
         end
      endcase

      ready_d    = (state_d == S_ACCEPT) ? grant_d : '0;
      tx_start_d = (state_d == S_START);
      busy_d     = (state_d != S_IDLE);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= S_IDLE;
         ptr_q      <= PTR_RST;
         cnt_q      <= '0;
         last_q     <= 1'b0;
         grant_q    <= '0;
         ready_q    <= '0;
         tx_start_q <= 1'b0;
         tx_data_q  <= '0;
         busy_q     <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         cnt_q      <= cnt_d;
         last_q     <= last_d;
         grant_q    <= grant_d;
         ready_q    <= ready_d;
         tx_start_q <= tx_start_d;
         tx_data_q  <= tx_data_d;
         busy_q     <= busy_d;
         timeout_q  <= timeout_d;
      end
   end

   assign o_req_ready = ready_q;
   assign o_grant     = grant_q;
   assign o_tx_start  = tx_start_q;
   assign o_tx_data   = tx_data_q;
   assign o_busy      = busy_q;
   assign o_timeout   = timeout_q;
   assign o_dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: producer and UART models, packet-level round-robin reference
// model feeding an expected byte queue, and directed scenario tasks.
module tb_uart_tx_arbiter;

   localparam int NUM_REQ = 2;
   localparam int TIMEOUT = 16;
   localparam int W       = 9;

   logic                 clk;
   logic                 rst_n;
   logic [NUM_REQ-1:0]   req_valid;
   logic [NUM_REQ*8-1:0] req_data;
   logic [NUM_REQ-1:0]   req_last;
   logic [NUM_REQ-1:0]   o_req_ready;
   logic [NUM_REQ-1:0]   o_grant;
   logic                 o_tx_start;
   logic [7:0]           o_tx_data;
   logic                 tx_busy;
   logic                 o_busy;
   logic                 o_timeout;
   logic [2:0]           o_dbg_state;

   int n_checks = 0;
   int n_pass   = 0;

   logic [W-1:0] exp_q [$];
   logic [8:0]   src_mem [NUM_REQ][64];
   int           src_wr  [NUM_REQ];
   int           src_rd  [NUM_REQ];
   int           gap_cnt [NUM_REQ];
   int           starts_seen [NUM_REQ];
   int           gap_max    = 0;
   int           busy_delay = 1;
   int           model_ptr  = NUM_REQ - 1;

   uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_req_valid (req_valid),
      .i_req_data  (req_data),
      .i_req_last  (req_last),
      .o_req_ready (o_req_ready),
      .o_grant     (o_grant),
      .o_tx_start  (o_tx_start),
      .o_tx_data   (o_tx_data),
      .i_tx_busy   (tx_busy),
      .o_busy      (o_busy),
      .o_timeout   (o_timeout),
      .o_dbg_state (o_dbg_state)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // producer model: presents queued bytes, advances after each accept pulse
   initial begin
      logic [NUM_REQ-1:0] rdy_seen;
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         src_wr[k] = 0; src_rd[k] = 0; gap_cnt[k] = 0; starts_seen[k] = 0;
      end
      forever begin
         @(negedge clk);
         rdy_seen = o_req_ready;
         @(posedge clk);
         #1;
         for (int k = 0; k < NUM_REQ; k++) begin
            if (rdy_seen[k] && req_valid[k]) begin
               if (!src_mem[k][src_rd[k]][8]) gap_cnt[k] = $urandom_range(0, gap_max);
               src_rd[k]    = src_rd[k] + 1;
               req_valid[k] = 1'b0;
            end
            if (!req_valid[k]) begin
               if (gap_cnt[k] > 0) begin
                  gap_cnt[k] = gap_cnt[k] - 1;
               end else if (src_rd[k] < src_wr[k]) begin
                  req_valid[k]        = 1'b1;
                  req_data[k*8 +: 8]  = src_mem[k][src_rd[k]][7:0];
                  req_last[k]         = src_mem[k][src_rd[k]][8];
               end
            end
         end
      end
   end

   // UART model: busy rises busy_delay cycles after start, lasts a random frame length
   initial begin
      tx_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (o_tx_start) begin
            repeat (busy_delay) @(posedge clk);
            #1 tx_busy = 1'b1;
            repeat ($urandom_range(3, 6)) @(posedge clk);
            #1 tx_busy = 1'b0;
         end
      end
   end

   // scoreboard: every start must carry the next expected {owner, byte}
   initial begin
      logic [W-1:0] got;
      logic [W-1:0] exp;
      forever begin
         @(negedge clk);
         if (o_tx_start) begin
            got = {o_grant[1], o_tx_data};
            n_checks++;
            if (exp_q.size() == 0) begin
               $display("FAIL sb_unexpected_start: got %h, required no start", got);
            end else begin
               exp = exp_q.pop_front();
               if (got !== exp || !$onehot(o_grant))
                  $display("FAIL sb_byte: got owner/byte %h grant %b, required %h", got, o_grant, exp);
               else
                  n_pass++;
            end
            if (o_grant[1]) starts_seen[1]++;
            else            starts_seen[0]++;
         end
         if (o_req_ready != '0) begin
            n_checks++;
            if (((o_req_ready & ~o_grant) != '0) || o_tx_start || tx_busy || !$onehot(o_req_ready))
               $display("FAIL ready_rule: ready %b grant %b start %b busy %b, required ready one-hot within grant while idle TX",
                        o_req_ready, o_grant, o_tx_start, tx_busy);
            else
               n_pass++;
         end
      end
   end

   // driver tasks
   task automatic push_byte(input int k, input logic [7:0] d, input logic last);
      src_mem[k][src_wr[k]] = {last, d};
      src_wr[k] = src_wr[k] + 1;
   endtask

   task automatic push_random_packets(input int k);
      int np;
      int nb;
      np = $urandom_range(1, 3);
      for (int p = 0; p < np; p++) begin
         nb = $urandom_range(1, 4);
         for (int b = 0; b < nb; b++) push_byte(k, 8'($urandom), (b == nb - 1));
      end
   endtask

   // reference model: whole packets, owners chosen round-robin among requesters with work
   task automatic build_expected();
      int  mrd [NUM_REQ];
      int  k;
      bit  picked;
      bit  last;
      for (int j = 0; j < NUM_REQ; j++) mrd[j] = src_rd[j];
      forever begin
         picked = 1'b0;
         k = 0;
         for (int i = 1; i <= NUM_REQ; i++) begin
            if (!picked && mrd[(model_ptr + i) % NUM_REQ] < src_wr[(model_ptr + i) % NUM_REQ]) begin
               picked = 1'b1;
               k = (model_ptr + i) % NUM_REQ;
            end
         end
         if (!picked) break;
         model_ptr = k;
         last = 1'b0;
         while (!last && mrd[k] < src_wr[k]) begin
            exp_q.push_back({k[0], src_mem[k][mrd[k]][7:0]});
            last = src_mem[k][mrd[k]][8];
            mrd[k]++;
         end
      end
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_ptr = NUM_REQ - 1;
   endtask

   task automatic wait_drain(input string name, input int budget);
      bit done;
      done = 1'b0;
      for (int c = 0; c < budget && !done; c++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !o_busy && !tx_busy &&
             src_rd[0] == src_wr[0] && src_rd[1] == src_wr[1]) done = 1'b1;
      end
      n_checks++;
      if (!done) $display("FAIL %s_drain: %0d bytes still expected after %0d cycles, required 0", name, exp_q.size(), budget);
      else n_pass++;
   endtask

   task automatic wait_grant(input string name);
      int c;
      c = 0;
      while (o_grant == '0 && c < 50) begin @(negedge clk); c++; end
      n_checks++;
      if (o_grant == '0) $display("FAIL %s_grant_wait: grant %b after 50 cycles, required nonzero", name, o_grant);
      else n_pass++;
   endtask

   task automatic wait_busy_level(input string name, input logic lvl);
      int c;
      c = 0;
      while (tx_busy !== lvl && c < 50) begin @(negedge clk); c++; end
      n_checks++;
      if (tx_busy !== lvl) $display("FAIL %s_busy_wait: busy %b, required %b", name, tx_busy, lvl);
      else n_pass++;
   endtask

   task automatic check_all_zero(input string name);
      n_checks++;
      if ({o_req_ready, o_grant, o_tx_start, o_tx_data, o_busy, o_timeout} !== '0)
         $display("FAIL %s: ready %b grant %b start %b data %h busy %b timeout %b, required all 0",
                  name, o_req_ready, o_grant, o_tx_start, o_tx_data, o_busy, o_timeout);
      else n_pass++;
   endtask

   // scenarios
   task automatic test_reset();
      rst_n = 1'b0;
      #2;
      check_all_zero("reset_outputs");
      n_checks++;
      if (o_dbg_state !== 3'd0) $display("FAIL reset_state: got %0d, required 0", o_dbg_state);
      else n_pass++;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset_held");
      rst_n = 1'b1;
      model_ptr = NUM_REQ - 1;
   endtask

   task automatic test_single_byte();
      int c;
      @(negedge clk);
      push_byte(0, 8'h41, 1'b1);
      build_expected();
      c = 0;
      while (!req_valid[0] && c < 10) begin @(negedge clk); c++; end
      n_checks++;
      if (o_grant !== 2'b00) $display("FAIL single_pre_grant: got %b, required 00", o_grant);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (o_grant !== 2'b01 || o_req_ready !== 2'b01)
         $display("FAIL single_cycle1: grant %b ready %b, required 01/01", o_grant, o_req_ready);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (o_tx_start !== 1'b1 || o_tx_data !== 8'h41 || o_req_ready !== 2'b00)
         $display("FAIL single_cycle2: start %b data %h ready %b, required 1/41/00", o_tx_start, o_tx_data, o_req_ready);
      else n_pass++;
      wait_busy_level("single_rise", 1'b1);
      wait_busy_level("single_fall", 1'b0);
      n_checks++;
      if (o_grant !== 2'b01) $display("FAIL single_grant_at_fall: got %b, required 01", o_grant);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (o_grant !== 2'b00 || o_busy !== 1'b0) $display("FAIL single_release: grant %b busy %b, required 00/0", o_grant, o_busy);
      else n_pass++;
      wait_drain("single", 100);
   endtask

   task automatic test_round_robin();
      apply_reset();
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         push_byte(0, 8'(8'h10 + i), 1'b1);
         push_byte(1, 8'(8'h20 + i), 1'b1);
      end
      build_expected();
      wait_grant("rr");
      n_checks++;
      if (o_grant !== 2'b01) $display("FAIL rr_first_owner: got %b, required 01", o_grant);
      else n_pass++;
      wait_drain("rr", 1000);
   endtask

   task automatic test_multi_byte();
      @(negedge clk);
      starts_seen[0] = 0;
      starts_seen[1] = 0;
      push_byte(0, 8'h22, 1'b1);
      push_byte(0, 8'h11, 1'b1);
      push_byte(1, 8'h55, 1'b0);
      push_byte(1, 8'hAA, 1'b0);
      push_byte(1, 8'h0D, 1'b1);
      build_expected();
      wait_drain("multi", 1000);
      n_checks++;
      if (starts_seen[1] !== 3 || starts_seen[0] !== 2)
         $display("FAIL multi_start_count: req1 %0d req0 %0d, required 3/2", starts_seen[1], starts_seen[0]);
      else n_pass++;
   endtask

   task automatic test_timeout();
      bit early;
      @(negedge clk);
      push_byte(0, 8'h33, 1'b0);
      exp_q.push_back({1'b0, 8'h33});
      wait_grant("to");
      n_checks++;
      if (o_grant !== 2'b01) $display("FAIL to_owner: got %b, required 01", o_grant);
      else n_pass++;
      push_byte(1, 8'h44, 1'b1);
      exp_q.push_back({1'b1, 8'h44});
      model_ptr = 1;
      wait_busy_level("to_rise", 1'b1);
      wait_busy_level("to_fall", 1'b0);
      early = 1'b0;
      for (int n = 1; n <= 16; n++) begin
         @(negedge clk);
         if (o_timeout || o_grant !== 2'b01) early = 1'b1;
      end
      n_checks++;
      if (early) $display("FAIL to_early: timeout or grant change within 16 HOLD cycles, required none");
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (o_timeout !== 1'b1 || o_grant !== 2'b00)
         $display("FAIL to_pulse: timeout %b grant %b, required 1/00", o_timeout, o_grant);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (o_timeout !== 1'b0 || o_grant !== 2'b10)
         $display("FAIL to_next_owner: timeout %b grant %b, required 0/10", o_timeout, o_grant);
      else n_pass++;
      wait_drain("to", 500);
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      push_byte(0, 8'h77, 1'b1);
      exp_q.push_back({1'b0, 8'h77});
      model_ptr = 0;
      wait_busy_level("rm_rise", 1'b1);
      @(negedge clk);
      n_checks++;
      if (o_busy !== 1'b1 || o_grant !== 2'b01) $display("FAIL rm_pre: busy %b grant %b, required 1/01", o_busy, o_grant);
      else n_pass++;
      #1 rst_n = 1'b0;
      #1;
      check_all_zero("rm_async_clear");
      wait_busy_level("rm_frame_end", 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_ptr = NUM_REQ - 1;
      @(negedge clk);
      push_byte(0, 8'h61, 1'b1);
      push_byte(1, 8'h62, 1'b1);
      build_expected();
      wait_grant("rm");
      n_checks++;
      if (o_grant !== 2'b01) $display("FAIL rm_first_owner: got %b, required 01", o_grant);
      else n_pass++;
      wait_drain("rm", 500);
   endtask

   task automatic test_slow_busy();
      int  c;
      int  extra;
      bit  data_moved;
      busy_delay = 5;
      @(negedge clk);
      push_byte(0, 8'h5A, 1'b0);
      push_byte(0, 8'hC3, 1'b1);
      build_expected();
      c = 0;
      while (!o_tx_start && c < 50) begin @(negedge clk); c++; end
      extra = 0;
      c = 0;
      while (c < 50) begin
         @(negedge clk);
         c++;
         if (tx_busy) break;
         if (o_tx_start) extra++;
      end
      n_checks++;
      if (c !== 5 || extra !== 0) $display("FAIL slow_wait_busy: busy after %0d cycles with %0d starts, required 5/0", c, extra);
      else n_pass++;
      data_moved = 1'b0;
      c = 0;
      while (!o_tx_start && c < 100) begin
         if (o_tx_data !== 8'h5A) data_moved = 1'b1;
         @(negedge clk);
         c++;
      end
      n_checks++;
      if (data_moved) $display("FAIL slow_data_hold: data left 5A before next accept, required stable 5A");
      else n_pass++;
      wait_drain("slow", 500);
      busy_delay = 1;
   endtask

   task automatic test_random();
      gap_max = 6;
      for (int r = 0; r < 4; r++) begin
         busy_delay = $urandom_range(1, 3);
         @(negedge clk);
         for (int k = 0; k < NUM_REQ; k++) push_random_packets(k);
         build_expected();
         wait_drain("rand", 5000);
      end
      gap_max = 0;
      busy_delay = 1;
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_round_robin();
      test_multi_byte();
      test_timeout();
      test_reset_mid();
      test_slow_busy();
      test_random();
      repeat (5) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
